// File: rtl/cam_cmd_loader.sv
// cam_cmd_loader: byte-stream command sequencer feeding the cam write port.
// Decodes opcode bytes (NOP / WRITE / BURST / CLEAR) arriving on a valid/ready
// stream and turns them into registered one-cycle cam write strobes.
module cam_cmd_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cam_write,
    output logic [ADDR_W-1:0] cam_addr,
    output logic [DATA_W-1:0] cam_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0]        OP_WRITE  = 2'b01;
    localparam logic [1:0]        OP_BURST  = 2'b10;
    localparam logic [1:0]        OP_CLEAR  = 2'b11;
    localparam logic [ADDR_W:0]   CNT_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_DATA,
        ST_B_CNT,
        ST_B_DATA,
        ST_CLR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_next;
    logic              r_cam_write;
    logic [ADDR_W-1:0] r_cam_addr;
    logic [DATA_W-1:0] r_cam_data;
    logic              r_done;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_done;
    logic              w_accept;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_base;
    logic              w_last;

    // The clear sweep owns the cam port, so the stream is stalled only there;
    // holding ready low during reset keeps the upstream demux from pushing bytes.
    assign in_ready  = rst_n && (r_state != ST_CLR);
    assign w_accept  = in_valid && in_ready;
    assign w_op      = in_data[7:6];
    assign w_base    = in_data[ADDR_W-1:0];
    assign w_last    = (r_count == CNT_ONE);
    assign busy      = (r_state != ST_IDLE);
    assign cam_write = r_cam_write;
    assign cam_addr  = r_cam_addr;
    assign cam_data  = r_cam_data;
    assign done      = r_done;

    // State register; reset drops any command in flight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: every state except CLR advances only on an accepted byte.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_WRITE: w_state_next = ST_W_DATA;
                        OP_BURST: w_state_next = ST_B_CNT;
                        OP_CLEAR: w_state_next = ST_CLR;
                        default:  w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_W_DATA: begin
                if (w_accept) w_state_next = ST_IDLE;
            end
            ST_B_CNT: begin
                if (w_accept) w_state_next = ST_B_DATA;
            end
            ST_B_DATA: begin
                if (w_accept && w_last) w_state_next = ST_IDLE;
            end
            ST_CLR: begin
                if (w_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output/datapath decode: next values for the write strobe, pointer and count.
    always_comb begin
        w_write      = 1'b0;
        w_addr       = '0;
        w_data       = '0;
        w_done       = 1'b0;
        w_ptr_next   = r_ptr;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_WRITE, OP_BURST: begin
                            w_ptr_next = w_base;
                        end
                        OP_CLEAR: begin
                            w_ptr_next   = '0;
                            w_count_next = CNT_DEPTH;
                        end
                        default: ;
                    endcase
                end
            end
            ST_W_DATA: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    w_addr  = r_ptr;
                    w_data  = in_data;
                    w_done  = 1'b1;
                end
            end
            ST_B_CNT: begin
                if (w_accept) begin
                    w_count_next = {1'b0, w_base} + CNT_ONE;
                end
            end
            ST_B_DATA: begin
                if (w_accept) begin
                    w_write      = 1'b1;
                    w_addr       = r_ptr;
                    w_data       = in_data;
                    w_done       = w_last;
                    w_ptr_next   = r_ptr + PTR_ONE;
                    w_count_next = r_count - CNT_ONE;
                end
            end
            ST_CLR: begin
                w_write      = 1'b1;
                w_addr       = r_ptr;
                w_data       = '0;
                w_done       = w_last;
                w_ptr_next   = r_ptr + PTR_ONE;
                w_count_next = r_count - CNT_ONE;
            end
            default: ;
        endcase
    end

    // Registered cam port and sequencing counters; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_cam_write <= 1'b0;
            r_cam_addr  <= '0;
            r_cam_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_next;
            r_count     <= w_count_next;
            r_cam_write <= w_write;
            r_cam_addr  <= w_addr;
            r_cam_data  <= w_data;
            r_done      <= w_done;
        end
    end

endmodule

// File: tb/tb_cam_cmd_loader.sv
// tb_cam_cmd_loader: directed bench for the cam command loader.
// A vector table covers single writes; hand sequences cover bursts, wrap,
// clear sweep, input gaps, reset mid-burst and the NOP / maximum burst cases.
module tb_cam_cmd_loader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] inData = '0;
   logic              inValid = 1'b0;
   logic              inReady;
   logic              camWrite;
   logic [ADDR_W-1:0] camAddr;
   logic [DATA_W-1:0] camData;
   logic              busy;
   logic              done;

   int testsRun = 0;
   int testsFailed = 0;
   int strayCount = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              done;
      logic              ready;
   } WriteRec;

   typedef struct {
      logic [7:0] opByte;
      logic [7:0] dataByte;
      logic [4:0] expAddr;
      logic [7:0] expData;
   } SingleVec;

   WriteRec writeLog[$];

   cam_cmd_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .cam_write (camWrite),
      .cam_addr  (camAddr),
      .cam_data  (camData),
      .busy      (busy),
      .done      (done)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Record every cam write mid-cycle and count outputs that leak outside a write.
   always @(negedge clk) begin
      if (camWrite) begin
         writeLog.push_back('{camAddr, camData, done, inReady});
      end else if (done || camAddr != '0 || camData != '0) begin
         strayCount++;
      end
   end

   // Hard stop in case something wedges despite the bounded waits.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offer one byte, wait (bounded) for ready, return #1 after the accepting edge.
   task automatic applyStimulus(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      inData  = b;
      inValid = 1'b1;
      while (!inReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!inReady) checkOutput("ready_timeout", 32'(inReady), 32'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inData  = '0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkWrite(input string name, input int idx, input logic [4:0] addr,
                             input logic [7:0] data, input logic dn);
      if (idx >= writeLog.size()) begin
         checkOutput({name, "_missing"}, 32'(writeLog.size()), 32'(idx + 1));
      end else begin
         checkOutput({name, "_addr"}, 32'(writeLog[idx].addr), 32'(addr));
         checkOutput({name, "_data"}, 32'(writeLog[idx].data), 32'(data));
         checkOutput({name, "_done"}, 32'(writeLog[idx].done), 32'(dn));
      end
   endtask

   SingleVec vecs[4];

   initial begin
      vecs[0] = '{8'h45, 8'hA5, 5'd5,  8'hA5};
      vecs[1] = '{8'h7F, 8'h3C, 5'd31, 8'h3C};
      vecs[2] = '{8'h60, 8'hFF, 5'd0,  8'hFF};
      vecs[3] = '{8'h4A, 8'h00, 5'd10, 8'h00};

      // Reset state
      #1;
      checkOutput("rst_ready", 32'(inReady), 32'd0);
      checkOutput("rst_write", 32'(camWrite), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      #22 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", 32'(inReady), 32'd1);

      // Single writes from the vector table
      for (int i = 0; i < 4; i++) begin
         writeLog.delete();
         applyStimulus(vecs[i].opByte);
         checkOutput("single_busy_mid", 32'(busy), 32'd1);
         checkOutput("single_nowrite_op", 32'(camWrite), 32'd0);
         applyStimulus(vecs[i].dataByte);
         checkOutput("single_write", 32'(camWrite), 32'd1);
         checkOutput("single_addr", 32'(camAddr), 32'(vecs[i].expAddr));
         checkOutput("single_data", 32'(camData), 32'(vecs[i].expData));
         checkOutput("single_done", 32'(done), 32'd1);
         checkOutput("single_busy_after", 32'(busy), 32'd0);
         idleCycles(2);
         checkOutput("single_count", 32'(writeLog.size()), 32'd1);
      end

      // Burst with address wrap
      writeLog.delete();
      applyStimulus(8'h9E);
      applyStimulus(8'h03);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      idleCycles(3);
      checkOutput("burst_count", 32'(writeLog.size()), 32'd4);
      checkWrite("burst_w0", 0, 5'd30, 8'h11, 1'b0);
      checkWrite("burst_w1", 1, 5'd31, 8'h22, 1'b0);
      checkWrite("burst_w2", 2, 5'd0,  8'h33, 1'b0);
      checkWrite("burst_w3", 3, 5'd1,  8'h44, 1'b1);
      checkOutput("burst_busy_after", 32'(busy), 32'd0);

      // Same burst with 3-cycle valid gaps between data bytes
      writeLog.delete();
      applyStimulus(8'h9E);
      applyStimulus(8'h03);
      applyStimulus(8'h11);
      idleCycles(3);
      checkOutput("gap_busy_hold", 32'(busy), 32'd1);
      applyStimulus(8'h22);
      idleCycles(3);
      applyStimulus(8'h33);
      idleCycles(3);
      checkOutput("gap_count_mid", 32'(writeLog.size()), 32'd3);
      applyStimulus(8'h44);
      idleCycles(3);
      checkOutput("gap_count", 32'(writeLog.size()), 32'd4);
      checkWrite("gap_w0", 0, 5'd30, 8'h11, 1'b0);
      checkWrite("gap_w1", 1, 5'd31, 8'h22, 1'b0);
      checkWrite("gap_w2", 2, 5'd0,  8'h33, 1'b0);
      checkWrite("gap_w3", 3, 5'd1,  8'h44, 1'b1);

      // Clear sweep; base address bits in the opcode are ignored
      writeLog.delete();
      applyStimulus(8'hC7);
      checkOutput("clr_ready_low", 32'(inReady), 32'd0);
      checkOutput("clr_busy", 32'(busy), 32'd1);
      idleCycles(40);
      checkOutput("clr_count", 32'(writeLog.size()), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         checkWrite("clr_w", i, 5'(i), 8'h00, (i == DEPTH - 1));
         if (i < DEPTH - 1 && i < writeLog.size())
            checkOutput("clr_ready_w", 32'(writeLog[i].ready), 32'd0);
      end
      checkOutput("clr_busy_after", 32'(busy), 32'd0);

      // Reset in the middle of a burst
      writeLog.delete();
      applyStimulus(8'h80);
      applyStimulus(8'h0F);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_write", 32'(camWrite), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_ready", 32'(inReady), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      idleCycles(3);
      rst_n = 1'b1;
      idleCycles(4);
      checkOutput("mid_rst_count", 32'(writeLog.size()), 32'd2);
      checkWrite("mid_rst_w0", 0, 5'd0, 8'h01, 1'b0);
      checkWrite("mid_rst_w1", 1, 5'd1, 8'h02, 1'b0);
      checkOutput("mid_rst_idle", 32'(busy), 32'd0);
      applyStimulus(8'h41);
      applyStimulus(8'h5A);
      idleCycles(2);
      checkOutput("post_rst_count", 32'(writeLog.size()), 32'd3);
      checkWrite("post_rst_w", 2, 5'd1, 8'h5A, 1'b1);

      // NOP followed by a full-depth burst starting at 0
      writeLog.delete();
      applyStimulus(8'h00);
      checkOutput("nop_busy", 32'(busy), 32'd0);
      idleCycles(2);
      checkOutput("nop_count", 32'(writeLog.size()), 32'd0);
      applyStimulus(8'h80);
      applyStimulus(8'h1F);
      for (int i = 0; i < DEPTH; i++) applyStimulus(8'(8'h40 + i));
      idleCycles(3);
      checkOutput("max_count", 32'(writeLog.size()), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++)
         checkWrite("max_w", i, 5'(i), 8'(8'h40 + i), (i == DEPTH - 1));
      checkOutput("max_busy_after", 32'(busy), 32'd0);

      checkOutput("stray_outputs", 32'(strayCount), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
